// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, and loads the IF/ID register.
// Define FETCH_STATS_EN to add saturating fetch/bubble counters as extra outputs.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0100_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] f_pc,
  output logic [31:0] f_inst,
  output logic        f_valid,
  output logic        halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fPc_q, fPc_d;
  logic [31:0] fInst_q, fInst_d;
  logic        fValid_q, fValid_d;
  logic        halted_q;
  logic        doAdvance, doBubble;

  // Redirect outranks halt so an older taken branch squashes a wrong-path ECALL;
  // halt is only honoured when the hazard unit is not stalling.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fPc_d     = fPc_q;
    fInst_d   = fInst_q;
    fValid_d  = fValid_q;
    doAdvance = 1'b0;
    doBubble  = 1'b0;
    if (state_q == RUN) begin
      if (redirect) begin
        pc_d     = {redirect_pc[31:2], 2'b00};
        fPc_d    = pc_q;
        fInst_d  = NOP_INST;
        fValid_d = 1'b0;
        doBubble = 1'b1;
      end else if (halt && !stall) begin
        state_d  = HALT;
        fInst_d  = NOP_INST;
        fValid_d = 1'b0;
        doBubble = 1'b1;
      end else if (!stall) begin
        pc_d      = pc_q + 32'd4;
        fPc_d     = pc_q;
        fInst_d   = imem_data;
        fValid_d  = 1'b1;
        doAdvance = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= PC_RESET;
      fPc_q    <= PC_RESET;
      fInst_q  <= NOP_INST;
      fValid_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fPc_q    <= fPc_d;
      fInst_q  <= fInst_d;
      fValid_q <= fValid_d;
      halted_q <= (state_d == HALT);
    end
  end

  assign imem_addr = pc_q;
  assign f_pc      = fPc_q;
  assign f_inst    = fInst_q;
  assign f_valid   = fValid_q;
  assign halted    = halted_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetchCount_q, bubbleCount_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetchCount_q  <= 32'd0;
      bubbleCount_q <= 32'd0;
    end else begin
      if (doAdvance && (fetchCount_q != 32'hFFFF_FFFF))
        fetchCount_q <= fetchCount_q + 32'd1;
      if (doBubble && (bubbleCount_q != 32'hFFFF_FFFF))
        bubbleCount_q <= bubbleCount_q + 32'd1;
    end
  end

  assign fetch_count  = fetchCount_q;
  assign bubble_count = bubbleCount_q;
`else
  logic unusedStats;
  assign unusedStats = doAdvance ^ doBubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem is modelled as word = addr ^ 32'hDEAD_BEEF.
module tb_fetch_stage;
  localparam logic [31:0] PCR = 32'h0100_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset, stall, redirect, halt;
  logic [31:0] redirectPc, imemAddr, imemData, fPc, fInst;
  logic        fValid, halted;
  int          checks = 0;
  int          errors = 0;
`ifdef FETCH_STATS_EN
  logic [31:0] fetchCount, bubbleCount;
`endif

  fetch_stage dut (
    .clock(clock), .reset(reset), .imem_addr(imemAddr), .imem_data(imemData),
    .stall(stall), .redirect(redirect), .redirect_pc(redirectPc), .halt(halt),
    .f_pc(fPc), .f_inst(fInst), .f_valid(fValid), .halted(halted)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetchCount), .bubble_count(bubbleCount)
`endif
  );

  always #5 clock = ~clock;
  assign imemData = imemAddr ^ 32'hDEAD_BEEF;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirectPc = 32'd0;
  endtask

  task automatic test_reset();
    clearInputs(); reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (imemAddr !== PCR) begin errors++; $display("[TB] FAIL reset_addr got %h want %h", imemAddr, PCR); end
    checks++; if (fInst !== NOP) begin errors++; $display("[TB] FAIL reset_inst got %h want %h", fInst, NOP); end
    checks++; if (fPc !== PCR) begin errors++; $display("[TB] FAIL reset_fpc got %h want %h", fPc, PCR); end
    checks++; if (fValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", fValid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b want 0", halted); end
    tick();
    checks++; if (imemAddr !== 32'h0100_0004) begin errors++; $display("[TB] FAIL run1_addr got %h want 01000004", imemAddr); end
    checks++; if (fInst !== word(PCR) || fPc !== PCR || fValid !== 1'b1) begin errors++; $display("[TB] FAIL run1_ifid got %h@%h v%b want %h@%h v1", fInst, fPc, fValid, word(PCR), PCR); end
    tick();
    checks++; if (imemAddr !== 32'h0100_0008) begin errors++; $display("[TB] FAIL run2_addr got %h want 01000008", imemAddr); end
    checks++; if (fInst !== word(32'h0100_0004) || fPc !== 32'h0100_0004) begin errors++; $display("[TB] FAIL run2_ifid got %h@%h want %h@01000004", fInst, fPc, word(32'h0100_0004)); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (imemAddr !== 32'h0100_0008) begin errors++; $display("[TB] FAIL stall_addr%0d got %h want 01000008", i, imemAddr); end
      checks++; if (fPc !== 32'h0100_0004 || fInst !== word(32'h0100_0004) || fValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_ifid%0d got %h@%h v%b", i, fInst, fPc, fValid); end
    end
    stall = 1'b0; tick();
    checks++; if (fPc !== 32'h0100_0008 || fInst !== word(32'h0100_0008) || imemAddr !== 32'h0100_000C) begin errors++; $display("[TB] FAIL stall_resume got %h@%h addr %h want %h@01000008 addr 0100000c", fInst, fPc, imemAddr, word(32'h0100_0008)); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirectPc = 32'h0100_0043; tick(); clearInputs();
    checks++; if (imemAddr !== 32'h0100_0040) begin errors++; $display("[TB] FAIL redir_addr got %h want 01000040", imemAddr); end
    checks++; if (fInst !== NOP || fValid !== 1'b0 || fPc !== 32'h0100_000C) begin errors++; $display("[TB] FAIL redir_flush got %h@%h v%b want %h@0100000c v0", fInst, fPc, fValid, NOP); end
    tick();
    checks++; if (fInst !== word(32'h0100_0040) || fPc !== 32'h0100_0040 || fValid !== 1'b1) begin errors++; $display("[TB] FAIL redir_target got %h@%h v%b want %h@01000040 v1", fInst, fPc, fValid, word(32'h0100_0040)); end
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirectPc = 32'h0100_0010; tick(); clearInputs();
    halt = 1'b1; tick(); clearInputs();
    checks++; if (halted !== 1'b1 || fValid !== 1'b0 || fInst !== NOP) begin errors++; $display("[TB] FAIL halt_enter got halted %b v%b inst %h want 1 0 %h", halted, fValid, fInst, NOP); end
    checks++; if (imemAddr !== 32'h0100_0010) begin errors++; $display("[TB] FAIL halt_pc got %h want 01000010", imemAddr); end
    redirect = 1'b1; redirectPc = 32'h0100_0080; tick(); tick(); clearInputs();
    checks++; if (imemAddr !== 32'h0100_0010 || halted !== 1'b1 || fValid !== 1'b0) begin errors++; $display("[TB] FAIL halt_ignore got addr %h halted %b v%b want 01000010 1 0", imemAddr, halted, fValid); end
    reset = 1'b1; tick(); clearInputs();
    checks++; if (imemAddr !== PCR || halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_reset got addr %h halted %b want %h 0", imemAddr, halted, PCR); end
  endtask

  task automatic test_halt_redirect();
    halt = 1'b1; redirect = 1'b1; redirectPc = 32'h0100_0100; tick(); clearInputs();
    checks++; if (halted !== 1'b0 || imemAddr !== 32'h0100_0100 || fValid !== 1'b0) begin errors++; $display("[TB] FAIL halt_redir got halted %b addr %h v%b want 0 01000100 0", halted, imemAddr, fValid); end
    halt = 1'b1; stall = 1'b1; tick(); clearInputs();
    checks++; if (halted !== 1'b0 || imemAddr !== 32'h0100_0100) begin errors++; $display("[TB] FAIL halt_stalled got halted %b addr %h want 0 01000100", halted, imemAddr); end
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirectPc = 32'h0100_0200; tick();
    redirectPc = 32'h0100_0300; tick(); clearInputs();
    checks++; if (imemAddr !== 32'h0100_0300 || fValid !== 1'b0 || fPc !== 32'h0100_0200) begin errors++; $display("[TB] FAIL b2b_flush got addr %h v%b fpc %h want 01000300 0 01000200", imemAddr, fValid, fPc); end
    tick();
    checks++; if (fInst !== word(32'h0100_0300) || fValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_target got %h v%b want %h v1", fInst, fValid, word(32'h0100_0300)); end
    stall = 1'b1; reset = 1'b1; tick(); clearInputs();
    checks++; if (imemAddr !== PCR || fInst !== NOP || fValid !== 1'b0 || fPc !== PCR) begin errors++; $display("[TB] FAIL reset_in_stall got addr %h inst %h v%b fpc %h", imemAddr, fInst, fValid, fPc); end
  endtask

  task automatic test_wrap();
    reset = 1'b1; tick(); clearInputs();
    redirect = 1'b1; redirectPc = 32'hFFFF_FFFC; tick(); clearInputs();
    checks++; if (imemAddr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap0 got %h want fffffffc", imemAddr); end
    tick();
    checks++; if (imemAddr !== 32'h0000_0000) begin errors++; $display("[TB] FAIL wrap1 got %h want 00000000", imemAddr); end
    tick();
    checks++; if (imemAddr !== 32'h0000_0004 || fPc !== 32'h0000_0000 || fInst !== word(32'h0)) begin errors++; $display("[TB] FAIL wrap2 got addr %h fpc %h inst %h", imemAddr, fPc, fInst); end
`ifdef FETCH_STATS_EN
    checks++; if (bubbleCount !== 32'd1 || fetchCount !== 32'd2) begin errors++; $display("[TB] FAIL stats got bubble %0d fetch %0d want 1 2", bubbleCount, fetchCount); end
`endif
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_halt_redirect();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the five-stage core.
- Owns the program counter and drives the instruction-memory address.
- Captures the returned word into the IF/ID pipeline register that feeds the decode/control logic.
- Handles hazard-unit stall, execute-stage redirect (taken branch/jump flush) and ECALL halt.

Parameters:
- PC_RESET, 32'h0100_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble word (addi x0,x0,0) inserted into IF/ID on flush/reset.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  32  current PC; imem returns data combinationally in the same cycle
- imem_data  in  32  instruction word at imem_addr
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect  in  1  execute stage: branch/jump taken
- redirect_pc  in  32  target PC for redirect
- halt  in  1  decode has an ECALL; stop fetching
- f_pc  out  32  IF/ID register: PC of f_inst
- f_inst  out  32  IF/ID register: instruction to decode
- f_valid  out  1  IF/ID register holds a real instruction (0 = bubble)
- halted  out  1  stage is in HALT state

Behaviour:
- Reset values: pc=PC_RESET, f_pc=PC_RESET, f_inst=NOP_INST, f_valid=0, state=RUN, halted=0.
- imem_addr = pc (combinational from the pc register).
- Latency: the word at PC X appears on f_inst/f_pc=X exactly one cycle after imem_addr=X.
- States: RUN, HALT. halted=1 iff state==HALT.
- Per-edge priority in RUN: reset > redirect > halt > stall > advance.
- advance:
  - pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - f_pc <= pc, f_inst <= imem_data, f_valid <= 1.
- stall:
  - pc, f_pc, f_inst and f_valid all hold.
  - imem_addr stays stable.
- redirect (including when stall=1 or halt=1 in the same cycle):
  - pc <= {redirect_pc[31:2],2'b00}; bits [1:0] are forced to zero and no misalignment trap is raised.
  - f_inst <= NOP_INST, f_valid <= 0, f_pc <= pc.
  - State stays RUN: the older redirect cancels a wrong-path ECALL.
- halt (redirect=0):
  - Sampled only when stall=0.
  - state <= HALT.
  - f_inst <= NOP_INST, f_valid <= 0; pc holds.
- HALT state:
  - pc and IF/ID hold their bubble.
  - stall, redirect and halt are all ignored.
  - Only reset leaves HALT.
- Reset asserted mid-stall, mid-redirect or in HALT returns every register to its reset value on that edge.
- Back-to-back redirects: each one reloads pc and re-flushes. The instruction fetched at the first target is discarded if the second redirect arrives on the next edge.
- Consecutive redirect to the current pc is legal and behaves as a normal flush.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds two output ports, fetch_count (32) and bubble_count (32). Both reset to 0.
  - fetch_count increments on every advance edge.
  - bubble_count increments on every edge where f_valid is loaded with 0 (redirect or halt entry).
  - Counts saturate at 32'hFFFF_FFFF.
  - Neither counter changes during stall or HALT.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then 3 free-running cycles with imem returning A,B,C:
  - imem_addr reads 0x0100_0000, then 0x0100_0004, then 0x0100_0008.
  - f_inst reads NOP/valid0, then A@0x0100_0000, then B@0x0100_0004.
- Stall held 2 cycles at pc=0x0100_0008: imem_addr, f_pc and f_inst are unchanged for both cycles, then advance resumes with f_pc=0x0100_0008.
- Redirect=1, redirect_pc=0x0100_0043 together with stall=1:
  - Next cycle pc=0x0100_0040 and f_inst=0x0000_0013 with f_valid=0.
  - The cycle after, f_inst is the word at 0x0100_0040.
- halt=1 at pc=0x0100_0010:
  - halted=1 and f_valid=0 from the next cycle on.
  - pc is frozen at 0x0100_0010; later redirect=1 is ignored.
  - reset restores pc=0x0100_0000 and halted=0.
- halt=1 and redirect=1 (redirect_pc=0x0100_0100) in the same cycle: halted stays 0 and pc=0x0100_0100.
- Redirect to 0xFFFF_FFFC, then advance twice: imem_addr reads 0xFFFF_FFFC, then 0x0000_0000, then 0x0000_0004.
  - With FETCH_STATS_EN: bubble_count=1 and fetch_count=2.
